// File: rtl/output_port_packetizer.sv
// rtl/output_port_packetizer.sv - credit-based BFT output port packetizer
// Optional OUT_PORT_CREDIT_CHECK_EN adds the sticky credit_err output.
module output_port_packetizer #(
  parameter int PACKET_BITS           = 97,
  parameter int NUM_LEAF_BITS         = 6,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int PAYLOAD_BITS          = 64,
  parameter int PORT_No               = 2,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ap_start,
  input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] dst_port,
  input  logic [PAYLOAD_BITS-1:0]  din_user,
  input  logic                     vld_user,
  output logic                     ack2user,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     resend,
  output logic [NUM_ADDR_BITS:0]   credit_cnt
`ifdef OUT_PORT_CREDIT_CHECK_EN
  ,
  output logic                     credit_err
`endif
);

  localparam int PAD_BITS = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS
                            - NUM_ADDR_BITS - PAYLOAD_BITS;
  localparam int CW      = NUM_ADDR_BITS + 1;
  localparam int PORT_HI = PACKET_BITS - 2 - NUM_LEAF_BITS;
  localparam int PORT_LO = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS;

  // One extra bit so credit + update never wraps before saturation.
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(2 ** NUM_ADDR_BITS);
  localparam logic [CW:0] UPD_SIZE   = (CW+1)'(FREESPACE_UPDATE_SIZE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state, state_next;
  logic [NUM_ADDR_BITS-1:0] addr;
  logic                     out_vld;
  logic                     fs_update;
  logic [CW:0]              credit_sum;
  logic                     credit_over;
  logic [CW-1:0]            credit_next;
  logic                     unused_din;

  assign out_vld = dout_leaf_interface2bft[PACKET_BITS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ap_start) state_next = RUN;
      RUN:  if (!ap_start && !(out_vld && resend)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ack2user = (state == RUN) && vld_user && (credit_cnt != '0) && !resend;

  assign fs_update = din_leaf_bft2interface[PACKET_BITS-1] &&
                     (din_leaf_bft2interface[PORT_HI:PORT_LO] == NUM_PORT_BITS'(PORT_No));

  assign unused_din = ^{din_leaf_bft2interface[PACKET_BITS-2:PORT_HI+1],
                        din_leaf_bft2interface[PORT_LO-1:0]};

  // A send only happens with credit >= 1, so the subtraction cannot underflow.
  assign credit_sum  = {1'b0, credit_cnt}
                     + (fs_update ? UPD_SIZE : '0)
                     - (ack2user ? (CW+1)'(1) : '0);
  assign credit_over = credit_sum > CREDIT_MAX;
  assign credit_next = credit_over ? CREDIT_MAX[CW-1:0] : credit_sum[CW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_cnt <= CREDIT_MAX[CW-1:0];
      addr       <= '0;
    end else begin
      credit_cnt <= credit_next;
      if (ack2user) addr <= addr + 1'b1;
    end
  end

  // Held packets stay put under resend; otherwise each packet lives one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_leaf_interface2bft <= '0;
    end else if (!resend) begin
      if (ack2user) begin
        dout_leaf_interface2bft <= {1'b1, dst_leaf, dst_port, {PAD_BITS{1'b0}},
                                    addr, din_user};
      end else begin
        dout_leaf_interface2bft[PACKET_BITS-1] <= 1'b0;
      end
    end
  end

`ifdef OUT_PORT_CREDIT_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_err <= 1'b0;
    end else if (credit_over || (ack2user && (credit_cnt == '0))) begin
      credit_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_output_port_packetizer.sv
// tb/tb_output_port_packetizer.sv - self-checking bench for output_port_packetizer
// Define OUT_PORT_CREDIT_CHECK_EN to also cover credit_err.
module tb_output_port_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic [5:0]  dst_leaf = 6'd5;
  logic [3:0]  dst_port = 4'd9;
  logic [63:0] din_user = '0;
  logic        vld_user = 1'b0;
  logic        ack2user;
  logic [96:0] din_leaf = '0;
  logic [96:0] dout;
  logic        resend = 1'b0;
  logic [7:0]  credit_cnt;
`ifdef OUT_PORT_CREDIT_CHECK_EN
  logic        credit_err;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int word_id = 0;
  bit cmp_en = 1'b0;

  // Spec-level model: credit as an integer, address as a counter, expected packet
  bit          m_run = 1'b0;
  int          m_credit = 128;
  int          m_addr = 0;
  logic [96:0] m_out = '0;
  bit          m_err = 1'b0;

  output_port_packetizer dut (
    .clk(clk),
    .reset(reset),
    .ap_start(ap_start),
    .dst_leaf(dst_leaf),
    .dst_port(dst_port),
    .din_user(din_user),
    .vld_user(vld_user),
    .ack2user(ack2user),
    .din_leaf_bft2interface(din_leaf),
    .dout_leaf_interface2bft(dout),
    .resend(resend),
    .credit_cnt(credit_cnt)
`ifdef OUT_PORT_CREDIT_CHECK_EN
    ,
    .credit_err(credit_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [96:0] mk_pkt(input logic [5:0] l, input logic [3:0] p,
                                         input int a, input logic [63:0] d);
    logic [96:0] r;
    r = '0;
    r[96] = 1'b1;
    r[95:90] = l;
    r[89:86] = p;
    r[70:64] = 7'(a);
    r[63:0] = d;
    return r;
  endfunction

  function automatic logic [96:0] upd_pkt(input logic [3:0] p);
    logic [96:0] r;
    r = '0;
    r[96] = 1'b1;
    r[95:90] = 6'd17;
    r[89:86] = p;
    r[40:0] = 41'h155;
    return r;
  endfunction

  always @(negedge clk) begin
    bit exp_ack;
    bit upd;
    bit held;
    int sum;
    if (cmp_en) begin
      exp_ack = m_run && vld_user && (m_credit != 0) && !resend;
      check("ack2user", ack2user, exp_ack);
      check("credit_cnt", credit_cnt, m_credit);
      check("dout", dout, m_out);
`ifdef OUT_PORT_CREDIT_CHECK_EN
      check("credit_err", credit_err, m_err);
`endif
      if (reset) begin
        m_run = 1'b0; m_credit = 128; m_addr = 0; m_out = '0; m_err = 1'b0;
      end else begin
        upd  = din_leaf[96] && (din_leaf[89:86] == 4'd2);
        held = m_out[96] && resend;
        sum  = m_credit + (upd ? 64 : 0) - (exp_ack ? 1 : 0);
        if (sum > 128) begin
          m_err = 1'b1;
          sum = 128;
        end
        m_credit = sum;
        if (exp_ack) begin
          m_out  = mk_pkt(dst_leaf, dst_port, m_addr, din_user);
          m_addr = (m_addr + 1) % 128;
        end else if (!resend) begin
          m_out[96] = 1'b0;
        end
        if (!m_run) m_run = ap_start;
        else if (!ap_start && !held) m_run = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_words(input int n);
    int got;
    int budget;
    got = 0;
    budget = 0;
    vld_user = 1'b1;
    din_user = 64'(word_id);
    while (got < n && budget < 2000) begin
      @(negedge clk);
      if (ack2user === 1'b1) begin
        got++;
        word_id++;
      end
      @(posedge clk);
      #1;
      din_user = 64'(word_id);
      budget++;
    end
    vld_user = 1'b0;
    check("burst_acks", got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1 cmp_en = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("rst_credit", credit_cnt, 128);
    check("rst_dout", dout, 0);
    check("rst_ack", ack2user, 0);

    // 128 words drain the full credit, addr 0..127
    cyc();
    ap_start = 1'b1;
    drive_words(128);
    vld_user = 1'b1;
    din_user = 64'd128;
    @(negedge clk);
    check("t1_last_pkt", dout, mk_pkt(6'd5, 4'd9, 127, 64'd127));
    check("t1_credit0", credit_cnt, 0);
    check("t1_word129_ack", ack2user, 0);

    // One matching update restores 64 credits, addr wraps to 0..63
    cyc();
    vld_user = 1'b0;
    din_leaf = upd_pkt(4'd2);
    cyc();
    din_leaf = '0;
    @(negedge clk);
    check("t2_credit64", credit_cnt, 64);
    cyc();
    drive_words(64);
    @(negedge clk);
    check("t2_credit0", credit_cnt, 0);
    check("t2_last_pkt", dout, mk_pkt(6'd5, 4'd9, 63, 64'd191));

    // Update for another port is ignored
    cyc();
    vld_user = 1'b1;
    din_leaf = upd_pkt(4'd3);
    cyc();
    din_leaf = '0;
    @(negedge clk);
    check("t3_credit", credit_cnt, 0);
    check("t3_ack", ack2user, 0);
    cyc();
    vld_user = 1'b0;

    // Resend holds the packet for 5 cycles
    din_leaf = upd_pkt(4'd2);
    cyc();
    din_leaf = '0;
    dst_leaf = 6'd33;
    dst_port = 4'd1;
    vld_user = 1'b1;
    din_user = 64'hA5;
    @(negedge clk);
    check("t4_ack_first", ack2user, 1);
    cyc();
    resend = 1'b1;
    din_user = 64'hB6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_held_pkt", dout, mk_pkt(6'd33, 4'd1, 64, 64'hA5));
      check("t4_held_ack", ack2user, 0);
      check("t4_held_credit", credit_cnt, 63);
      cyc();
    end
    resend = 1'b0;
    @(negedge clk);
    check("t4_release_ack", ack2user, 1);
    cyc();
    vld_user = 1'b0;
    @(negedge clk);
    check("t4_next_pkt", dout, mk_pkt(6'd33, 4'd1, 65, 64'hB6));
    check("t4_credit62", credit_cnt, 62);

    // Send and update in the same cycle at credit 10
    cyc();
    word_id = 300;
    drive_words(52);
    @(negedge clk);
    check("t5_credit10", credit_cnt, 10);
    cyc();
    vld_user = 1'b1;
    din_user = 64'h1234;
    din_leaf = upd_pkt(4'd2);
    @(negedge clk);
    check("t5_ack", ack2user, 1);
    cyc();
    vld_user = 1'b0;
    din_leaf = '0;
    @(negedge clk);
    check("t5_credit73", credit_cnt, 73);

    // Updates count in IDLE and saturate; IDLE does not reset credit
    cyc();
    ap_start = 1'b0;
    cyc();
    vld_user = 1'b1;
    din_leaf = upd_pkt(4'd2);
    cyc();
    din_leaf = '0;
    @(negedge clk);
    check("idle_ack", ack2user, 0);
    check("idle_credit_sat", credit_cnt, 128);
`ifdef OUT_PORT_CREDIT_CHECK_EN
    check("idle_err_set", credit_err, 1);
`endif
    cyc();
    ap_start = 1'b1;
    @(negedge clk);
    check("restart_ack_idle", ack2user, 0);
    cyc();
    @(negedge clk);
    check("restart_ack_run", ack2user, 1);
    cyc();
    vld_user = 1'b0;

    // Saturation at full credit, then reset mid-burst
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("t6_rst_credit", credit_cnt, 128);
    cyc();
    din_leaf = upd_pkt(4'd2);
    cyc();
    din_leaf = '0;
    @(negedge clk);
    check("t6_sat_credit", credit_cnt, 128);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
`ifdef OUT_PORT_CREDIT_CHECK_EN
      check("t6_err_sticky", credit_err, 1);
`else
      check("t6_credit_hold", credit_cnt, 128);
`endif
    end
    cyc();
    vld_user = 1'b1;
    din_user = 64'd7;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    vld_user = 1'b0;
    @(negedge clk);
    check("t6_mid_rst_dout", dout, 0);
    check("t6_mid_rst_credit", credit_cnt, 128);
`ifdef OUT_PORT_CREDIT_CHECK_EN
    check("t6_mid_rst_err", credit_err, 0);
`endif
    cyc();
    vld_user = 1'b1;
    din_user = 64'd99;
    @(negedge clk);
    check("t6_post_rst_ack", ack2user, 1);
    cyc();
    vld_user = 1'b0;
    @(negedge clk);
    check("t6_addr_restart", dout, mk_pkt(6'd33, 4'd1, 0, 64'd99));

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
